hps_reset_req_sequencer: RTL and testbench



---
 rtl/hps_reset_req_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_hps_reset_req_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hps_reset_req_sequencer.sv
// hps_reset_req_sequencer
// Turns FPGA-side reset requesters (push-buttons, watchdog) into minimum-width,
// priority-arbitrated, active-low reset requests toward the HPS. It follows the
// HPS acknowledgement seen on h2f_reset_n and emits one-cycle trace pulses for
// the HPS STM hardware-event input.
module hps_reset_req_sequencer #(
   parameter int PULSE_CYCLES   = 16,
   parameter int HOLDOFF_CYCLES = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_W          = 17
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        req_cold,
   input  logic        req_warm,
   input  logic        req_debug,
   input  logic        h2f_reset_n,
   output logic        f2h_cold_reset_req_n,
   output logic        f2h_warm_reset_req_n,
   output logic        f2h_debug_reset_req_n,
   output logic [27:0] stm_hwevents,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ASSERT   = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_WAIT_REL = 3'd3,
      ST_HOLDOFF  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SEL_COLD  = 2'd0,
      SEL_WARM  = 2'd1,
      SEL_DEBUG = 2'd2
   } sel_t;

   // Terminal counts: the counter starts at 0 on state entry, so a phase of
   // N cycles ends on the edge where the counter holds N-1.
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // Event bit positions inside the 6 live STM bits.
   localparam int EV_COLD    = 0;
   localparam int EV_WARM    = 1;
   localparam int EV_DEBUG   = 2;
   localparam int EV_ACK     = 3;
   localparam int EV_REL     = 4;
   localparam int EV_TIMEOUT = 5;

   // Request bit order in the pending / edge vectors: {debug, warm, cold}.
   logic             r_h2f_meta;
   logic             r_h2f_s;
   logic             r_prev_cold;
   logic             r_prev_warm;
   logic             r_prev_debug;
   logic [2:0]       r_pend;
   state_t           r_state;
   sel_t             r_sel;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cold_n;
   logic             r_warm_n;
   logic             r_debug_n;
   logic [5:0]       r_stm;

   logic [2:0]       w_edge;
   logic [2:0]       w_clr;
   logic [2:0]       w_pend_nxt;
   state_t           w_state_nxt;
   sel_t             w_sel_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [5:0]       w_stm_nxt;
   logic             w_cold_n_nxt;
   logic             w_warm_n_nxt;
   logic             w_debug_n_nxt;

   assign w_edge = {req_debug & ~r_prev_debug,
                    req_warm  & ~r_prev_warm,
                    req_cold  & ~r_prev_cold};

   // Synchronise h2f_reset_n and keep the previous request levels for edge detection.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_h2f_meta   <= 1'b1;
         r_h2f_s      <= 1'b1;
         r_prev_cold  <= 1'b1;
         r_prev_warm  <= 1'b1;
         r_prev_debug <= 1'b1;
      end else begin
         r_h2f_meta   <= h2f_reset_n;
         r_h2f_s      <= r_h2f_meta;
         r_prev_cold  <= req_cold;
         r_prev_warm  <= req_warm;
         r_prev_debug <= req_debug;
      end
   end

   // Next-state, counter, arbitration and registered-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_clr       = 3'b000;
      w_stm_nxt   = 6'b000000;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (r_pend[0]) begin
               w_sel_nxt          = SEL_COLD;
               w_clr              = 3'b111;
               w_stm_nxt[EV_COLD] = 1'b1;
               w_state_nxt        = ST_ASSERT;
            end else if (r_pend[1]) begin
               w_sel_nxt          = SEL_WARM;
               w_clr              = 3'b110;
               w_stm_nxt[EV_WARM] = 1'b1;
               w_state_nxt        = ST_ASSERT;
            end else if (r_pend[2]) begin
               w_sel_nxt           = SEL_DEBUG;
               w_clr               = 3'b100;
               w_stm_nxt[EV_DEBUG] = 1'b1;
               w_state_nxt         = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (r_cnt == PULSE_LAST) begin
               w_cnt_nxt   = '0;
               // Debug reset gives no h2f_reset_n handshake to wait for.
               w_state_nxt = (r_sel == SEL_DEBUG) ? ST_HOLDOFF : ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (!r_h2f_s) begin
               w_cnt_nxt         = '0;
               w_stm_nxt[EV_ACK] = 1'b1;
               w_state_nxt       = ST_WAIT_REL;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_cnt_nxt             = '0;
               w_stm_nxt[EV_TIMEOUT] = 1'b1;
               w_state_nxt           = ST_HOLDOFF;
            end
         end
         ST_WAIT_REL: begin
            if (r_h2f_s) begin
               w_cnt_nxt         = '0;
               w_stm_nxt[EV_REL] = 1'b1;
               w_state_nxt       = ST_HOLDOFF;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_cnt_nxt             = '0;
               w_stm_nxt[EV_TIMEOUT] = 1'b1;
               w_state_nxt           = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (r_cnt == HOLDOFF_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      // A new edge in the same cycle as a grant-clear keeps the flag set.
      w_pend_nxt = (r_pend & ~w_clr) | w_edge;

      // Only the one selected output can be low, and only while in ASSERT.
      w_cold_n_nxt  = !((w_state_nxt == ST_ASSERT) && (w_sel_nxt == SEL_COLD));
      w_warm_n_nxt  = !((w_state_nxt == ST_ASSERT) && (w_sel_nxt == SEL_WARM));
      w_debug_n_nxt = !((w_state_nxt == ST_ASSERT) && (w_sel_nxt == SEL_DEBUG));
   end

   // FSM state, counter, selection and pending flags.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state <= ST_IDLE;
         r_sel   <= SEL_COLD;
         r_cnt   <= '0;
         r_pend  <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Registered request outputs and STM event pulses.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_cold_n  <= 1'b1;
         r_warm_n  <= 1'b1;
         r_debug_n <= 1'b1;
         r_stm     <= 6'b000000;
      end else begin
         r_cold_n  <= w_cold_n_nxt;
         r_warm_n  <= w_warm_n_nxt;
         r_debug_n <= w_debug_n_nxt;
         r_stm     <= w_stm_nxt;
      end
   end

   assign f2h_cold_reset_req_n  = r_cold_n;
   assign f2h_warm_reset_req_n  = r_warm_n;
   assign f2h_debug_reset_req_n = r_debug_n;
   assign stm_hwevents          = {22'd0, r_stm};
   assign busy                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Directed bench for hps_reset_req_sequencer with PULSE=4, HOLDOFF=8, TIMEOUT=32.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_hps_reset_req_sequencer;

   localparam int P_PULSE   = 4;
   localparam int P_HOLDOFF = 8;
   localparam int P_TIMEOUT = 32;
   localparam int P_CNT_W   = 6;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        req_cold;
   logic        req_warm;
   logic        req_debug;
   logic        h2f_reset_n;
   logic        f2h_cold_reset_req_n;
   logic        f2h_warm_reset_req_n;
   logic        f2h_debug_reset_req_n;
   logic [27:0] stm_hwevents;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   hps_reset_req_sequencer #(
      .PULSE_CYCLES  (P_PULSE),
      .HOLDOFF_CYCLES(P_HOLDOFF),
      .TIMEOUT_CYCLES(P_TIMEOUT),
      .CNT_W         (P_CNT_W)
   ) dut (
      .clk_clk              (clk_clk),
      .reset_reset          (reset_reset),
      .req_cold             (req_cold),
      .req_warm             (req_warm),
      .req_debug            (req_debug),
      .h2f_reset_n          (h2f_reset_n),
      .f2h_cold_reset_req_n (f2h_cold_reset_req_n),
      .f2h_warm_reset_req_n (f2h_warm_reset_req_n),
      .f2h_debug_reset_req_n(f2h_debug_reset_req_n),
      .stm_hwevents         (stm_hwevents),
      .busy                 (busy)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int t, input logic c_n, input logic w_n,
                          input logic d_n, input logic [27:0] stm, input logic b);
      chk({tag, "_cold_n"},  t, 32'(f2h_cold_reset_req_n),  32'(c_n));
      chk({tag, "_warm_n"},  t, 32'(f2h_warm_reset_req_n),  32'(w_n));
      chk({tag, "_debug_n"}, t, 32'(f2h_debug_reset_req_n), 32'(d_n));
      chk({tag, "_stm"},     t, 32'(stm_hwevents),          32'(stm));
      chk({tag, "_busy"},    t, 32'(busy),                  32'(b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_reset = 1'b1;
      req_cold    = 1'b0;
      req_warm    = 1'b0;
      req_debug   = 1'b0;
      h2f_reset_n = 1'b1;

      // Reset state
      repeat (3) tick();
      chk_all("reset", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      reset_reset = 1'b0;
      tick();
      chk_all("idle", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);

      // Cold pulse with full HPS handshake: h2f low 3 cycles after release, for 10 cycles
      req_cold = 1'b1;
      tick();
      chk_all("cold", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      for (int t = 1; t <= 30; t++) begin
         tick();
         chk_all("cold", t, !(t >= 1 && t <= 4), 1'b1, 1'b1,
                 (t == 1) ? 28'h1 : (t == 10) ? 28'h8 : (t == 20) ? 28'h10 : 28'h0,
                 (t <= 27));
         if (t == 7)  h2f_reset_n = 1'b0;
         if (t == 17) h2f_reset_n = 1'b1;
      end
      req_cold = 1'b0;
      tick();

      // Warm and debug rise together; warm wins, HPS never answers -> timeout
      req_warm  = 1'b1;
      req_debug = 1'b1;
      tick();
      chk_all("wd", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      for (int t = 1; t <= 50; t++) begin
         tick();
         chk_all("wd", t, 1'b1, !(t >= 1 && t <= 4), 1'b1,
                 (t == 1) ? 28'h2 : (t == 37) ? 28'h20 : 28'h0,
                 (t <= 44));
      end
      req_warm  = 1'b0;
      req_debug = 1'b0;
      tick();

      // Debug alone: pulse then holdoff, no handshake phases
      req_debug = 1'b1;
      tick();
      chk_all("dbg", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      for (int t = 1; t <= 16; t++) begin
         tick();
         chk_all("dbg", t, 1'b1, 1'b1, !(t >= 1 && t <= 4),
                 (t == 1) ? 28'h4 : 28'h0,
                 (t <= 12));
      end
      req_debug = 1'b0;
      tick();

      // Warm with handshake; debug requested twice while busy, served once after holdoff
      req_warm = 1'b1;
      tick();
      chk_all("wq", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      for (int t = 1; t <= 45; t++) begin
         tick();
         chk_all("wq", t, 1'b1, !(t >= 1 && t <= 4), !(t >= 27 && t <= 30),
                 (t == 1) ? 28'h2 : (t == 8) ? 28'h8 : (t == 18) ? 28'h10 :
                 (t == 27) ? 28'h4 : 28'h0,
                 (t <= 25) || (t >= 27 && t <= 38));
         if (t == 5)  h2f_reset_n = 1'b0;
         if (t == 15) h2f_reset_n = 1'b1;
         if (t == 10) req_debug = 1'b1;
         if (t == 12) req_debug = 1'b0;
         if (t == 14) req_debug = 1'b1;
         if (t == 16) req_debug = 1'b0;
      end
      req_warm = 1'b0;
      tick();

      // Reset during the second ASSERT cycle of a cold pulse; request stays high
      req_cold = 1'b1;
      tick();
      chk_all("rst", 0, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      tick();
      chk_all("rst", 1, 1'b0, 1'b1, 1'b1, 28'h1, 1'b1);
      tick();
      chk_all("rst", 2, 1'b0, 1'b1, 1'b1, 28'h0, 1'b1);
      reset_reset = 1'b1;
      tick();
      chk_all("rst", 3, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      reset_reset = 1'b0;
      for (int t = 4; t <= 20; t++) begin
         tick();
         chk_all("rst", t, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);
      end
      req_cold = 1'b0;
      tick();
      chk_all("rst", 21, 1'b1, 1'b1, 1'b1, 28'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
